// File: rtl/input_load_ctrl.sv
// input_load_ctrl
//   Sequencer between the input FIFO read side and the on-chip memories. Consumes
//   the serial word stream in three phases (KD-tree internal nodes, leaves, query
//   patches), assembles each record and issues one wide write per record to the
//   node, leaf or query memory. Sticky phase-complete flags report load status.
// Ports
//   clk, rst_n                         core clock, async active-low reset
//   load_kdtree / load_query           1-cycle start pulses (full load / queries only)
//   in_fifo_rempty_n, in_fifo_rdata    FWFT FIFO head word and its valid
//   in_fifo_deq                        pop head word (combinational)
//   node_wen/waddr/wdim/wmedian        internal node write port
//   leaf_wen/waddr/wsel/wdata          leaf patch write port {idx, elem4..elem0}
//   query_wen/waddr/wdata              query patch write port {elem4..elem0}
//   kdtree_loaded, queries_loaded      sticky completion flags
//   busy                               loading in progress (NODE, LEAF or QUERY)
module input_load_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int LEAF_ADDRW = 6,
  parameter int NUM_QUERYS = 494,
  localparam int QADDRW    = $clog2(NUM_QUERYS),
  localparam int LSELW     = $clog2(LEAF_SIZE)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    load_kdtree,
  input  logic                                    load_query,
  input  logic                                    in_fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0]                   in_fifo_rdata,
  output logic                                    in_fifo_deq,
  output logic                                    node_wen,
  output logic [LEAF_ADDRW-1:0]                   node_waddr,
  output logic [2:0]                              node_wdim,
  output logic [DATA_WIDTH-1:0]                   node_wmedian,
  output logic                                    leaf_wen,
  output logic [LEAF_ADDRW-1:0]                   leaf_waddr,
  output logic [LSELW-1:0]                        leaf_wsel,
  output logic [PATCH_SIZE*DATA_WIDTH+IDX_WIDTH-1:0] leaf_wdata,
  output logic                                    query_wen,
  output logic [QADDRW-1:0]                       query_waddr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]        query_wdata,
  output logic                                    kdtree_loaded,
  output logic                                    queries_loaded,
  output logic                                    busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NODE  = 3'd1;
  localparam logic [2:0] S_LEAF  = 3'd2;
  localparam logic [2:0] S_QUERY = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [LEAF_ADDRW-1:0] LAST_NODE  = LEAF_ADDRW'(NUM_LEAVES - 2);
  localparam logic [LEAF_ADDRW-1:0] LAST_LEAF  = LEAF_ADDRW'(NUM_LEAVES - 1);
  localparam logic [LSELW-1:0]      LAST_SLOT  = LSELW'(LEAF_SIZE - 1);
  localparam logic [QADDRW-1:0]     LAST_QUERY = QADDRW'(NUM_QUERYS - 1);
  localparam logic [2:0]            LEAF_IDXW  = 3'(PATCH_SIZE);
  localparam logic [2:0]            QUERY_LASTW = 3'(PATCH_SIZE - 1);
  localparam int                    QBUFW      = (PATCH_SIZE - 1) * DATA_WIDTH;

  logic [2:0]                       state;
  logic [2:0]                       word_cnt;
  logic [LEAF_ADDRW-1:0]            node_cnt;
  logic [LEAF_ADDRW-1:0]            leaf_cnt;
  logic [LSELW-1:0]                 slot_cnt;
  logic [QADDRW-1:0]                query_cnt;
  logic [2:0]                       dim_buf;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] elem_buf;

  assign busy        = (state == S_NODE) || (state == S_LEAF) || (state == S_QUERY);
  assign in_fifo_deq = busy & in_fifo_rempty_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      word_cnt       <= '0;
      node_cnt       <= '0;
      leaf_cnt       <= '0;
      slot_cnt       <= '0;
      query_cnt      <= '0;
      dim_buf        <= '0;
      elem_buf       <= '0;
      node_wen       <= 1'b0;
      node_waddr     <= '0;
      node_wdim      <= '0;
      node_wmedian   <= '0;
      leaf_wen       <= 1'b0;
      leaf_waddr     <= '0;
      leaf_wsel      <= '0;
      leaf_wdata     <= '0;
      query_wen      <= 1'b0;
      query_waddr    <= '0;
      query_wdata    <= '0;
      kdtree_loaded  <= 1'b0;
      queries_loaded <= 1'b0;
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      // A word popped in the same cycle as a load pulse is discarded.
      if (load_kdtree) begin
        state          <= S_NODE;
        word_cnt       <= '0;
        node_cnt       <= '0;
        leaf_cnt       <= '0;
        slot_cnt       <= '0;
        query_cnt      <= '0;
        kdtree_loaded  <= 1'b0;
        queries_loaded <= 1'b0;
      end else if (load_query && !busy) begin
        state          <= S_QUERY;
        word_cnt       <= '0;
        query_cnt      <= '0;
        queries_loaded <= 1'b0;
      end else if (in_fifo_deq) begin
        case (state)
          S_NODE: begin
            if (word_cnt == 3'd0) begin
              dim_buf  <= in_fifo_rdata[2:0];
              word_cnt <= 3'd1;
            end else begin
              node_wen     <= 1'b1;
              node_waddr   <= node_cnt;
              node_wdim    <= dim_buf;
              node_wmedian <= in_fifo_rdata;
              word_cnt     <= '0;
              if (node_cnt == LAST_NODE) begin
                node_cnt <= '0;
                state    <= S_LEAF;
              end else begin
                node_cnt <= node_cnt + 1'b1;
              end
            end
          end
          S_LEAF: begin
            if (word_cnt == LEAF_IDXW) begin
              leaf_wen   <= 1'b1;
              leaf_waddr <= leaf_cnt;
              leaf_wsel  <= slot_cnt;
              leaf_wdata <= {in_fifo_rdata[IDX_WIDTH-1:0], elem_buf};
              word_cnt   <= '0;
              if (slot_cnt == LAST_SLOT) begin
                slot_cnt <= '0;
                if (leaf_cnt == LAST_LEAF) begin
                  leaf_cnt      <= '0;
                  kdtree_loaded <= 1'b1;
                  state         <= S_QUERY;
                end else begin
                  leaf_cnt <= leaf_cnt + 1'b1;
                end
              end else begin
                slot_cnt <= slot_cnt + 1'b1;
              end
            end else begin
              elem_buf[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= in_fifo_rdata;
              word_cnt <= word_cnt + 1'b1;
            end
          end
          S_QUERY: begin
            // The last element goes straight from the FIFO into the write data.
            if (word_cnt == QUERY_LASTW) begin
              query_wen   <= 1'b1;
              query_waddr <= query_cnt;
              query_wdata <= {in_fifo_rdata, elem_buf[QBUFW-1:0]};
              word_cnt    <= '0;
              if (query_cnt == LAST_QUERY) begin
                query_cnt      <= '0;
                queries_loaded <= 1'b1;
                state          <= S_DONE;
              end else begin
                query_cnt <= query_cnt + 1'b1;
              end
            end else begin
              elem_buf[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= in_fifo_rdata;
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_load_ctrl.sv
module tb_input_load_ctrl;
  localparam int DW  = 11;
  localparam int IW  = 9;
  localparam int PS  = 5;
  localparam int LS  = 8;
  localparam int NL  = 64;
  localparam int LAW = 6;
  localparam int NQ  = 494;
  localparam int NN  = NL - 1;
  localparam int QAW = $clog2(NQ);
  localparam int NODE_WORDS  = 2 * NN;
  localparam int LEAF_WORDS  = NL * LS * 6;
  localparam int QUERY_WORDS = NQ * 5;
  localparam int TOTAL_WORDS = NODE_WORDS + LEAF_WORDS + QUERY_WORDS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_kdtree = 1'b0;
  logic load_query = 1'b0;
  logic in_fifo_rempty_n = 1'b0;
  logic [DW-1:0] in_fifo_rdata = '0;
  logic in_fifo_deq;
  logic node_wen;
  logic [LAW-1:0] node_waddr;
  logic [2:0] node_wdim;
  logic [DW-1:0] node_wmedian;
  logic leaf_wen;
  logic [LAW-1:0] leaf_waddr;
  logic [2:0] leaf_wsel;
  logic [PS*DW+IW-1:0] leaf_wdata;
  logic query_wen;
  logic [QAW-1:0] query_waddr;
  logic [PS*DW-1:0] query_wdata;
  logic kdtree_loaded;
  logic queries_loaded;
  logic busy;

  always #5 clk = ~clk;

  input_load_ctrl #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .PATCH_SIZE(PS), .LEAF_SIZE(LS),
    .NUM_LEAVES(NL), .LEAF_ADDRW(LAW), .NUM_QUERYS(NQ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_kdtree(load_kdtree), .load_query(load_query),
    .in_fifo_rempty_n(in_fifo_rempty_n), .in_fifo_rdata(in_fifo_rdata),
    .in_fifo_deq(in_fifo_deq),
    .node_wen(node_wen), .node_waddr(node_waddr), .node_wdim(node_wdim),
    .node_wmedian(node_wmedian),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wsel(leaf_wsel),
    .leaf_wdata(leaf_wdata),
    .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
    .kdtree_loaded(kdtree_loaded), .queries_loaded(queries_loaded), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] fifo_q[$];
  bit gaps = 0;
  bit last_acc;
  int acc_since = 0;
  int viol = 0;
  int n_node = 0, n_leaf = 0, n_query = 0;
  logic [DW+2:0] node_img[NN];
  logic [63:0] leaf_img[NL*LS];
  logic [54:0] query_img[NQ];
  logic [DW-1:0] words[TOTAL_WORDS];

  typedef struct {
    logic [DW-1:0]  w0;
    logic [DW-1:0]  w1;
    logic [LAW-1:0] addr;
    logic [2:0]     dim;
    logic [DW-1:0]  med;
  } node_vec_t;
  node_vec_t nv[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fifo_q.size() > 0 && (!gaps || $urandom_range(1, 0) == 1)) begin
      in_fifo_rempty_n = 1'b1;
      in_fifo_rdata    = fifo_q[0];
    end else begin
      in_fifo_rempty_n = 1'b0;
      in_fifo_rdata    = DW'($urandom);
    end
  endtask

  // Record every memory write and flag-timing / spacing rule violations.
  task automatic monitor();
    if (int'(node_wen) + int'(leaf_wen) + int'(query_wen) > 1) viol++;
    if (node_wen) begin
      if (acc_since < 2) viol++;
      acc_since = 0;
      if (int'(node_waddr) < NN) node_img[node_waddr] = {node_wdim, node_wmedian};
      n_node++;
    end
    if (leaf_wen) begin
      if (acc_since < 6) viol++;
      acc_since = 0;
      leaf_img[{leaf_waddr, leaf_wsel}] = leaf_wdata;
      n_leaf++;
      if (kdtree_loaded !== (n_leaf == NL * LS)) viol++;
    end
    if (query_wen) begin
      if (acc_since < 5) viol++;
      acc_since = 0;
      if (int'(query_waddr) < NQ) query_img[query_waddr] = query_wdata;
      n_query++;
      if (queries_loaded !== (n_query == NQ)) viol++;
    end
  endtask

  task automatic tick();
    drive_fifo();
    #1;
    last_acc = in_fifo_deq;
    if (in_fifo_deq && !in_fifo_rempty_n) viol++;
    @(posedge clk);
    if (last_acc) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      acc_since++;
    end
    @(negedge clk);
    load_kdtree = 1'b0;
    load_query  = 1'b0;
    monitor();
  endtask

  task automatic run_until_empty(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fifo_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check({name, "_drained"}, ok, 1);
  endtask

  task automatic clear_state();
    n_node = 0; n_leaf = 0; n_query = 0; viol = 0; acc_since = 0;
    foreach (node_img[i]) node_img[i] = '1;
    foreach (leaf_img[i]) leaf_img[i] = '1;
    foreach (query_img[i]) query_img[i] = '1;
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
  endtask

  task automatic compare_queries(input string tag);
    logic [54:0] e;
    for (int q = 0; q < NQ; q++) begin
      e = '0;
      for (int k = 0; k < PS; k++) e[k*DW +: DW] = words[NODE_WORDS + LEAF_WORDS + 5*q + k];
      check($sformatf("%s_query%0d", tag, q), query_img[q], e);
    end
  endtask

  task automatic compare_tree(input string tag);
    logic [63:0] e;
    int b;
    for (int n = 0; n < NN; n++) begin
      check($sformatf("%s_node%0d_dim", tag, n), node_img[n][DW+2:DW], words[2*n][2:0]);
      check($sformatf("%s_node%0d_med", tag, n), node_img[n][DW-1:0], words[2*n+1]);
    end
    for (int p = 0; p < NL * LS; p++) begin
      b = NODE_WORDS + 6 * p;
      e = '0;
      for (int k = 0; k < PS; k++) e[k*DW +: DW] = words[b + k];
      e[PS*DW +: IW] = words[b + 5][IW-1:0];
      check($sformatf("%s_leaf%0d", tag, p), leaf_img[p], e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_deq"}, in_fifo_deq, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {kdtree_loaded, queries_loaded}, 0);
    check({tag, "_strobes"}, {node_wen, leaf_wen, query_wen}, 0);
    check({tag, "_node"}, {node_waddr, node_wdim, node_wmedian}, 0);
    check({tag, "_leaf_addr"}, {leaf_waddr, leaf_wsel}, 0);
    check({tag, "_leaf_data"}, leaf_wdata, 0);
    check({tag, "_query"}, query_waddr, 0);
    check({tag, "_query_data"}, query_wdata, 0);
  endtask

  task automatic full_run(input bit g, input string tag);
    clear_state();
    fifo_q = {};
    for (int i = 0; i < TOTAL_WORDS; i++) fifo_q.push_back(words[i]);
    gaps = g;
    load_kdtree = 1'b1;
    tick();
    run_until_empty(40000, tag);
    tick();
    check({tag, "_n_node"}, n_node, NN);
    check({tag, "_n_leaf"}, n_leaf, NL * LS);
    check({tag, "_n_query"}, n_query, NQ);
    check({tag, "_flags"}, {kdtree_loaded, queries_loaded}, 2'b11);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rules"}, viol, 0);
    compare_tree(tag);
    compare_queries(tag);
    push_random(3);
    repeat (5) tick();
    check({tag, "_no_deq_after"}, fifo_q.size(), 3);
    fifo_q = {};
  endtask

  initial begin
    logic [63:0] exp_leaf;
    nv[0] = '{w0: 11'd3,     w1: 11'd700,  addr: 6'd0, dim: 3'd3, med: 11'd700};
    nv[1] = '{w0: 11'h7FD,   w1: 11'h7FF,  addr: 6'd1, dim: 3'd5, med: 11'h7FF};
    nv[2] = '{w0: 11'd8,     w1: 11'd0,    addr: 6'd2, dim: 3'd0, med: 11'd0};
    nv[3] = '{w0: 11'h402,   w1: 11'd1234, addr: 6'd3, dim: 3'd2, med: 11'd1234};
    for (int i = 0; i < TOTAL_WORDS; i++) words[i] = DW'($urandom);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    full_run(0, "nogap");

    // Query-only reload from DONE with new query data.
    for (int i = NODE_WORDS + LEAF_WORDS; i < TOTAL_WORDS; i++) words[i] = DW'($urandom);
    clear_state();
    for (int i = NODE_WORDS + LEAF_WORDS; i < TOTAL_WORDS; i++) fifo_q.push_back(words[i]);
    gaps = 1;
    load_query = 1'b1;
    tick();
    check("reload_q_flag_cleared", {kdtree_loaded, queries_loaded}, 2'b10);
    run_until_empty(20000, "reload_q");
    check("reload_q_only_queries", {n_node[15:0], n_leaf[15:0], n_query[15:0]}, {16'd0, 16'd0, 16'(NQ)});
    check("reload_q_flags", {kdtree_loaded, queries_loaded, busy}, 3'b110);
    check("reload_q_rules", viol, 0);
    compare_queries("reload_q");

    full_run(1, "gaps");

    // Restart from DONE: flags must clear, node vectors from the table.
    clear_state();
    gaps = 0;
    load_kdtree = 1'b1;
    tick();
    check("restart_flags", {kdtree_loaded, queries_loaded, busy}, 3'b001);
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(nv[i].w0);
      fifo_q.push_back(nv[i].w1);
      tick();
      check($sformatf("vec%0d_wen_early", i), node_wen, 0);
      tick();
      check($sformatf("vec%0d_wen", i), node_wen, 1);
      check($sformatf("vec%0d_addr", i), node_waddr, nv[i].addr);
      check($sformatf("vec%0d_dim", i), node_wdim, nv[i].dim);
      check($sformatf("vec%0d_med", i), node_wmedian, nv[i].med);
    end
    push_random(2 * (NN - 4));
    run_until_empty(500, "rest_nodes");
    check("rest_nodes_count", n_node, NN);

    fifo_q.push_back(11'd1); fifo_q.push_back(11'd2); fifo_q.push_back(11'd3);
    fifo_q.push_back(11'd4); fifo_q.push_back(11'd5); fifo_q.push_back(11'd300);
    run_until_empty(20, "leaf0");
    exp_leaf = {9'd300, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    check("leaf0_wen", leaf_wen, 1);
    check("leaf0_data", leaf_wdata, exp_leaf);
    check("leaf0_addr", {leaf_waddr, leaf_wsel}, 0);
    push_random(7 * 6);
    run_until_empty(100, "leaf1_7");
    push_random(6);
    run_until_empty(20, "patch8");
    check("patch8_wen", leaf_wen, 1);
    check("patch8_addr", {leaf_waddr, leaf_wsel}, {6'd1, 3'd0});

    // Advance into leaf 10 with a partial patch, then restart.
    push_random((80 - 9) * 6 + 3);
    run_until_empty(1000, "to_leaf10");
    tick();
    check("leaf10_last_write", {leaf_waddr, leaf_wsel}, {6'd9, 3'd7});
    check("leaf10_state", {kdtree_loaded, queries_loaded, busy}, 3'b001);
    load_kdtree = 1'b1;
    acc_since = 0;
    tick();
    check("midleaf_flags", {kdtree_loaded, queries_loaded, busy}, 3'b001);
    fifo_q.push_back(11'd5);
    fifo_q.push_back(11'd900);
    tick();
    tick();
    check("midleaf_node0", {node_wen, node_waddr, node_wdim, node_wmedian}, {1'b1, 6'd0, 3'd5, 11'd900});

    // Asynchronous reset in the middle of a query load.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_state();
    load_query = 1'b1;
    tick();
    push_random(100);
    repeat (30) tick();
    check("preq_count", n_query, 6);
    check("preq_state", {query_waddr, queries_loaded, busy}, {9'd5, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_no_deq", fifo_q.size(), 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
